// File: rtl/alu_arbiter_if.sv
// Bundle between two ALU requesters, the round-robin arbiter and the shared ALU.
// The arbiter sits on the slave modport; the requesters and the ALU drive the master side.
interface alu_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
);
   logic             r0_req;
   logic [OPW-1:0]   r0_op;
   logic [WIDTH-1:0] r0_a;
   logic [WIDTH-1:0] r0_b;
   logic [2:0]       r0_ltgt;
   logic             r0_eq;
   logic             r0_ack;
   logic             r0_done;
   logic [WIDTH-1:0] r0_out;
   logic             r0_cmp;

   logic             r1_req;
   logic [OPW-1:0]   r1_op;
   logic [WIDTH-1:0] r1_a;
   logic [WIDTH-1:0] r1_b;
   logic [2:0]       r1_ltgt;
   logic             r1_eq;
   logic             r1_ack;
   logic             r1_done;
   logic [WIDTH-1:0] r1_out;
   logic             r1_cmp;

   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] alu_register;
   logic [2:0]       alu_ltgt;
   logic             alu_eq;
   logic [WIDTH-1:0] alu_out;
   logic             alu_compres;

   modport master (
      output r0_req, r0_op, r0_a, r0_b, r0_ltgt, r0_eq,
      output r1_req, r1_op, r1_a, r1_b, r1_ltgt, r1_eq,
      output alu_out, alu_compres,
      input  r0_ack, r0_done, r0_out, r0_cmp,
      input  r1_ack, r1_done, r1_out, r1_cmp,
      input  alu_op, alu_res, alu_register, alu_ltgt, alu_eq
   );

   modport slave (
      input  r0_req, r0_op, r0_a, r0_b, r0_ltgt, r0_eq,
      input  r1_req, r1_op, r1_a, r1_b, r1_ltgt, r1_eq,
      input  alu_out, alu_compres,
      output r0_ack, r0_done, r0_out, r0_cmp,
      output r1_ack, r1_done, r1_out, r1_cmp,
      output alu_op, alu_res, alu_register, alu_ltgt, alu_eq
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Three-cycle IDLE/EXEC/DONE sequence: grant and register operands, capture result, signal done.
module alu_arbiter #(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) (
   input logic         clock,
   input logic         reset,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           r_state;
   logic             r_last;
   logic             r_cur;
   logic [1:0]       r_ack;
   logic [1:0]       r_done;
   logic [WIDTH-1:0] r_out0;
   logic [WIDTH-1:0] r_out1;
   logic             r_cmp0;
   logic             r_cmp1;
   logic [OPW-1:0]   r_aluOp;
   logic [WIDTH-1:0] r_aluRes;
   logic [WIDTH-1:0] r_aluRegister;
   logic [2:0]       r_aluLtgt;
   logic             r_aluEq;

   logic w_anyReq;
   logic w_bothReq;
   logic w_winner;

   // On a tie the requester that did not win the previous tie goes first.
   assign w_anyReq  = bus.r0_req | bus.r1_req;
   assign w_bothReq = bus.r0_req & bus.r1_req;
   assign w_winner  = w_bothReq ? ~r_last : bus.r1_req;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= IDLE;
         r_last        <= 1'b1;
         r_cur         <= 1'b0;
         r_ack         <= '0;
         r_done        <= '0;
         r_out0        <= '0;
         r_out1        <= '0;
         r_cmp0        <= 1'b0;
         r_cmp1        <= 1'b0;
         r_aluOp       <= '0;
         r_aluRes      <= '0;
         r_aluRegister <= '0;
         r_aluLtgt     <= '0;
         r_aluEq       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_anyReq) begin
                  r_state <= EXEC;
                  r_cur   <= w_winner;
                  r_ack   <= w_winner ? 2'b10 : 2'b01;
                  if (w_bothReq) r_last <= w_winner;
                  if (w_winner) begin
                     r_aluOp       <= bus.r1_op;
                     r_aluRes      <= bus.r1_a;
                     r_aluRegister <= bus.r1_b;
                     r_aluLtgt     <= bus.r1_ltgt;
                     r_aluEq       <= bus.r1_eq;
                  end else begin
                     r_aluOp       <= bus.r0_op;
                     r_aluRes      <= bus.r0_a;
                     r_aluRegister <= bus.r0_b;
                     r_aluLtgt     <= bus.r0_ltgt;
                     r_aluEq       <= bus.r0_eq;
                  end
               end
            end
            EXEC: begin
               r_state <= DONE;
               r_ack   <= '0;
               r_done  <= r_cur ? 2'b10 : 2'b01;
               // Only the current winner's result registers move; the other side holds.
               if (r_cur) begin
                  r_out1 <= bus.alu_out;
                  r_cmp1 <= bus.alu_compres;
               end else begin
                  r_out0 <= bus.alu_out;
                  r_cmp0 <= bus.alu_compres;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.r0_ack       = r_ack[0];
   assign bus.r1_ack       = r_ack[1];
   assign bus.r0_done      = r_done[0];
   assign bus.r1_done      = r_done[1];
   assign bus.r0_out       = r_out0;
   assign bus.r1_out       = r_out1;
   assign bus.r0_cmp       = r_cmp0;
   assign bus.r1_cmp       = r_cmp1;
   assign bus.alu_op       = r_aluOp;
   assign bus.alu_res      = r_aluRes;
   assign bus.alu_register = r_aluRegister;
   assign bus.alu_ltgt     = r_aluLtgt;
   assign bus.alu_eq       = r_aluEq;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a small ALU model, a table of single-requester ops,
// and hand-written sequences for ties, back-to-back grants, reset mid-op and late requests.
module tb_alu_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [15:0] modelOut [2];
   logic        modelCmp [2];

   alu_arbiter_if #(.WIDTH(16), .OPW(4)) bus ();

   alu_arbiter #(.WIDTH(16), .OPW(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 compare (ltgt[0]=lt, ltgt[1]=gt, eq=equal).
   always_comb begin
      bus.alu_out     = 16'h0000;
      bus.alu_compres = 1'b0;
      case (bus.alu_op)
         4'd0: bus.alu_out = bus.alu_res + bus.alu_register;
         4'd1: bus.alu_out = bus.alu_res - bus.alu_register;
         4'd2: bus.alu_out = bus.alu_res & bus.alu_register;
         4'd3: bus.alu_out = bus.alu_res | bus.alu_register;
         4'd4: bus.alu_compres = (bus.alu_eq && (bus.alu_res == bus.alu_register)) ||
                                 (bus.alu_ltgt[0] && (bus.alu_res < bus.alu_register)) ||
                                 (bus.alu_ltgt[1] && (bus.alu_res > bus.alu_register));
         default: bus.alu_out = bus.alu_res ^ bus.alu_register;
      endcase
   end

   typedef struct {
      logic        sel;
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  ltgt;
      logic        eq;
      logic [15:0] expOut;
      logic        expCmp;
   } vec_t;

   vec_t vecs [8];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic sel, input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic [2:0] ltgt, input logic eq);
      if (sel) begin
         bus.r1_op = op; bus.r1_a = a; bus.r1_b = b; bus.r1_ltgt = ltgt; bus.r1_eq = eq;
         bus.r1_req = 1'b1;
      end else begin
         bus.r0_op = op; bus.r0_a = a; bus.r0_b = b; bus.r0_ltgt = ltgt; bus.r0_eq = eq;
         bus.r0_req = 1'b1;
      end
   endtask

   task automatic dropReq(input logic sel);
      if (sel) bus.r1_req = 1'b0;
      else     bus.r0_req = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_r0_ack"}, 32'(bus.r0_ack), 0);
      checkOutput({tag, "_r1_ack"}, 32'(bus.r1_ack), 0);
      checkOutput({tag, "_r0_done"}, 32'(bus.r0_done), 0);
      checkOutput({tag, "_r1_done"}, 32'(bus.r1_done), 0);
      checkOutput({tag, "_r0_out"}, 32'(bus.r0_out), 0);
      checkOutput({tag, "_r1_out"}, 32'(bus.r1_out), 0);
      checkOutput({tag, "_r0_cmp"}, 32'(bus.r0_cmp), 0);
      checkOutput({tag, "_r1_cmp"}, 32'(bus.r1_cmp), 0);
      checkOutput({tag, "_alu_op"}, 32'(bus.alu_op), 0);
      checkOutput({tag, "_alu_res"}, 32'(bus.alu_res), 0);
      checkOutput({tag, "_alu_register"}, 32'(bus.alu_register), 0);
      checkOutput({tag, "_alu_ltgt"}, 32'(bus.alu_ltgt), 0);
      checkOutput({tag, "_alu_eq"}, 32'(bus.alu_eq), 0);
   endtask

   task automatic resetDut(input string tag);
      reset = 1'b1;
      bus.r0_req = 1'b0;
      bus.r1_req = 1'b0;
      step();
      step();
      checkAllZero(tag);
      modelOut[0] = 16'h0; modelOut[1] = 16'h0;
      modelCmp[0] = 1'b0;  modelCmp[1] = 1'b0;
      reset = 1'b0;
   endtask

   // One complete op by a single requester, starting and ending in an IDLE cycle.
   task automatic runVector(input vec_t v, input int idx);
      logic other;
      other = ~v.sel;
      applyStimulus(v.sel, v.op, v.a, v.b, v.ltgt, v.eq);
      step();
      checkOutput($sformatf("v%0d_ack", idx), 32'(v.sel ? bus.r1_ack : bus.r0_ack), 1);
      checkOutput($sformatf("v%0d_other_ack", idx), 32'(other ? bus.r1_ack : bus.r0_ack), 0);
      checkOutput($sformatf("v%0d_done_early", idx), 32'(v.sel ? bus.r1_done : bus.r0_done), 0);
      checkOutput($sformatf("v%0d_alu_op", idx), 32'(bus.alu_op), 32'(v.op));
      checkOutput($sformatf("v%0d_alu_res", idx), 32'(bus.alu_res), 32'(v.a));
      checkOutput($sformatf("v%0d_alu_register", idx), 32'(bus.alu_register), 32'(v.b));
      checkOutput($sformatf("v%0d_alu_ltgt", idx), 32'(bus.alu_ltgt), 32'(v.ltgt));
      checkOutput($sformatf("v%0d_alu_eq", idx), 32'(bus.alu_eq), 32'(v.eq));
      dropReq(v.sel);
      step();
      checkOutput($sformatf("v%0d_done", idx), 32'(v.sel ? bus.r1_done : bus.r0_done), 1);
      checkOutput($sformatf("v%0d_ack_late", idx), 32'(v.sel ? bus.r1_ack : bus.r0_ack), 0);
      checkOutput($sformatf("v%0d_other_done", idx), 32'(other ? bus.r1_done : bus.r0_done), 0);
      checkOutput($sformatf("v%0d_out", idx), 32'(v.sel ? bus.r1_out : bus.r0_out), 32'(v.expOut));
      checkOutput($sformatf("v%0d_cmp", idx), 32'(v.sel ? bus.r1_cmp : bus.r0_cmp), 32'(v.expCmp));
      checkOutput($sformatf("v%0d_other_out", idx), 32'(other ? bus.r1_out : bus.r0_out),
                  32'(modelOut[other]));
      checkOutput($sformatf("v%0d_other_cmp", idx), 32'(other ? bus.r1_cmp : bus.r0_cmp),
                  32'(modelCmp[other]));
      modelOut[v.sel] = v.expOut;
      modelCmp[v.sel] = v.expCmp;
      step();
      checkOutput($sformatf("v%0d_done_gone", idx), 32'(v.sel ? bus.r1_done : bus.r0_done), 0);
      checkOutput($sformatf("v%0d_alu_op_hold", idx), 32'(bus.alu_op), 32'(v.op));
      checkOutput($sformatf("v%0d_alu_res_hold", idx), 32'(bus.alu_res), 32'(v.a));
   endtask

   initial begin
      bus.r0_req = 1'b0; bus.r0_op = '0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_ltgt = '0; bus.r0_eq = 1'b0;
      bus.r1_req = 1'b0; bus.r1_op = '0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_ltgt = '0; bus.r1_eq = 1'b0;

      vecs[0] = '{1'b0, 4'd0, 16'h0003, 16'h0004, 3'd0, 1'b0, 16'h0007, 1'b0};
      vecs[1] = '{1'b1, 4'd4, 16'h0005, 16'h0005, 3'd1, 1'b1, 16'h0000, 1'b1};
      vecs[2] = '{1'b0, 4'd1, 16'h0010, 16'h0001, 3'd0, 1'b0, 16'h000F, 1'b0};
      vecs[3] = '{1'b1, 4'd2, 16'hF0F0, 16'h0FF0, 3'd0, 1'b0, 16'h00F0, 1'b0};
      vecs[4] = '{1'b0, 4'd4, 16'h0003, 16'h0005, 3'd1, 1'b0, 16'h0000, 1'b1};
      vecs[5] = '{1'b1, 4'd4, 16'h0007, 16'h0005, 3'd1, 1'b0, 16'h0000, 1'b0};
      vecs[6] = '{1'b0, 4'd0, 16'hFFFF, 16'h0001, 3'd0, 1'b0, 16'h0000, 1'b0};
      vecs[7] = '{1'b1, 4'd3, 16'h8000, 16'h0001, 3'd0, 1'b0, 16'h8001, 1'b0};

      resetDut("reset");
      for (int i = 0; i < 8; i++) runVector(vecs[i], i);

      // Simultaneous requests right after reset: r0 first, r1 waits while held.
      resetDut("tie_reset");
      applyStimulus(1'b0, 4'd1, 16'h0009, 16'h0002, 3'd0, 1'b0);
      applyStimulus(1'b1, 4'd3, 16'h00F0, 16'h000F, 3'd0, 1'b0);
      step();
      checkOutput("tie_r0_ack", 32'(bus.r0_ack), 1);
      checkOutput("tie_r1_ack", 32'(bus.r1_ack), 0);
      dropReq(1'b0);
      step();
      checkOutput("tie_r0_done", 32'(bus.r0_done), 1);
      checkOutput("tie_r0_out", 32'(bus.r0_out), 32'h0007);
      step();
      checkOutput("tie_idle_r1_ack", 32'(bus.r1_ack), 0);
      step();
      checkOutput("tie_r1_ack_late", 32'(bus.r1_ack), 1);
      dropReq(1'b1);
      step();
      checkOutput("tie_r1_done", 32'(bus.r1_done), 1);
      checkOutput("tie_r1_out", 32'(bus.r1_out), 32'h00FF);
      checkOutput("tie_r0_out_hold", 32'(bus.r0_out), 32'h0007);
      step();

      // Both held high: six grants alternating r0,r1 with one op every three cycles.
      resetDut("b2b_reset");
      applyStimulus(1'b0, 4'd0, 16'h0001, 16'h0002, 3'd0, 1'b0);
      applyStimulus(1'b1, 4'd0, 16'h000A, 16'h0014, 3'd0, 1'b0);
      for (int c = 0; c < 18; c++) begin
         int k;
         int g;
         k = c % 3;
         g = c / 3;
         step();
         checkOutput($sformatf("b2b_c%0d_r0_ack", c), 32'(bus.r0_ack), 32'((k == 0) && (g % 2 == 0)));
         checkOutput($sformatf("b2b_c%0d_r1_ack", c), 32'(bus.r1_ack), 32'((k == 0) && (g % 2 == 1)));
         checkOutput($sformatf("b2b_c%0d_r0_done", c), 32'(bus.r0_done), 32'((k == 1) && (g % 2 == 0)));
         checkOutput($sformatf("b2b_c%0d_r1_done", c), 32'(bus.r1_done), 32'((k == 1) && (g % 2 == 1)));
         if (k == 1 && g % 2 == 0) checkOutput($sformatf("b2b_c%0d_r0_out", c), 32'(bus.r0_out), 32'h0003);
         if (k == 1 && g % 2 == 1) checkOutput($sformatf("b2b_c%0d_r1_out", c), 32'(bus.r1_out), 32'h001E);
      end
      dropReq(1'b0);
      dropReq(1'b1);
      step();
      checkOutput("b2b_stop_r0_ack", 32'(bus.r0_ack), 0);
      checkOutput("b2b_stop_r1_ack", 32'(bus.r1_ack), 0);

      // Reset during EXEC drops the op; the following tie goes back to r0.
      resetDut("mid_reset_pre");
      applyStimulus(1'b1, 4'd0, 16'h0003, 16'h0004, 3'd0, 1'b0);
      step();
      checkOutput("mid_r1_ack", 32'(bus.r1_ack), 1);
      reset = 1'b1;
      dropReq(1'b1);
      step();
      checkAllZero("mid_reset");
      reset = 1'b0;
      applyStimulus(1'b0, 4'd0, 16'h0001, 16'h0001, 3'd0, 1'b0);
      applyStimulus(1'b1, 4'd0, 16'h0002, 16'h0002, 3'd0, 1'b0);
      step();
      checkOutput("mid_tie_r0_ack", 32'(bus.r0_ack), 1);
      checkOutput("mid_tie_r1_ack", 32'(bus.r1_ack), 0);
      dropReq(1'b0);
      dropReq(1'b1);
      step();
      checkOutput("mid_tie_r0_done", 32'(bus.r0_done), 1);
      checkOutput("mid_tie_r0_out", 32'(bus.r0_out), 32'h0002);
      checkOutput("mid_tie_r1_done", 32'(bus.r1_done), 0);
      step();

      // r1 raises req during r0's DONE cycle: granted at the following IDLE edge.
      applyStimulus(1'b0, 4'd0, 16'h0003, 16'h0004, 3'd0, 1'b0);
      step();
      checkOutput("late_r0_ack", 32'(bus.r0_ack), 1);
      dropReq(1'b0);
      step();
      checkOutput("late_r0_done", 32'(bus.r0_done), 1);
      applyStimulus(1'b1, 4'd2, 16'h00FF, 16'h0F0F, 3'd0, 1'b0);
      step();
      checkOutput("late_idle_r1_ack", 32'(bus.r1_ack), 0);
      step();
      checkOutput("late_r1_ack", 32'(bus.r1_ack), 1);
      checkOutput("late_r1_done_early", 32'(bus.r1_done), 0);
      dropReq(1'b1);
      step();
      checkOutput("late_r1_done", 32'(bus.r1_done), 1);
      checkOutput("late_r1_out", 32'(bus.r1_out), 32'h000F);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
